// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding, pipeline
// stall vector constants and the all-zero data word.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIfAcc  = 2'd1,
        StMemAcc = 2'd2,
        StResp   = 2'd3
    } arb_state_e;

    // Stall vector bits: 0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb, 5 reserved
    localparam logic [5:0]  StallNone = 6'b000000;
    localparam logic [5:0]  StallIf   = 6'b000011;
    localparam logic [5:0]  StallMem  = 6'b001111;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates a single-ported memory bus between the instruction-fetch port
// (if_*) and the MEM-stage port (mem_*). MEM wins simultaneous requests.
// A granted access holds the bus until bus_ack or until ACK_TIMEOUT cycles
// pass without an ack, then a one-cycle response state pulses the granted
// port's ready.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request and address
//   if_rdata/if_ready              fetch read data (held) and one-cycle ready
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_sel              MEM-stage request and payload
//   mem_rdata/mem_ready            MEM-stage read data (held) and ready
//   bus_req/bus_we/bus_addr/
//   bus_wdata/bus_sel              registered shared-bus request
//   bus_rdata/bus_ack              shared-bus response
//   stall                          combinational pipeline stall vector
//   bus_err                        one-cycle pulse on access timeout
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [5:0]  stall,
    output logic        bus_err
);

    localparam logic [7:0] TimeoutCnt = 8'(ACK_TIMEOUT);

    arb_state_e  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        bus_err_q, bus_err_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= ZeroWord;
            bus_wdata_q <= ZeroWord;
            bus_sel_q   <= '0;
            if_rdata_q  <= ZeroWord;
            mem_rdata_q <= ZeroWord;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    state_d     = StMemAcc;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_sel_d   = mem_sel;
                    cnt_d       = '0;
                end else if (if_req) begin
                    state_d     = StIfAcc;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = ZeroWord;
                    bus_sel_d   = 4'b1111;
                    cnt_d       = '0;
                end
            end

            StIfAcc, StMemAcc: begin
                if (bus_ack) begin
                    state_d   = StResp;
                    bus_req_d = 1'b0;
                    if (state_q == StIfAcc) begin
                        if_rdata_d = bus_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        // Writes return no data.
                        mem_rdata_d = bus_we_q ? ZeroWord : bus_rdata;
                        mem_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // Abort on the cycle the count reaches the limit, so the
                    // access lasts exactly ACK_TIMEOUT cycles.
                    if (cnt_d == TimeoutCnt) begin
                        state_d   = StResp;
                        bus_req_d = 1'b0;
                        bus_err_d = 1'b1;
                        if (state_q == StIfAcc) begin
                            if_rdata_d = ZeroWord;
                            if_ready_d = 1'b1;
                        end else begin
                            mem_rdata_d = ZeroWord;
                            mem_ready_d = 1'b1;
                        end
                    end
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        stall = StallNone;
        if (mem_req && !mem_ready_q) begin
            stall = StallMem;
        end else if (if_req && !if_ready_q) begin
            stall = StallIf;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (ACK_TIMEOUT overridden to 4).
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [5:0]  stall;
    logic        bus_err;

    bus_arbiter #(.ACK_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int unsigned delay;      // cycles of bus_req before ack; >=4 means no ack
        logic [31:0] bus_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        is_mem;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          bus_txn = 0;
    int          exp_txn = 0;
    logic        bus_req_prev = 1'b0;
    vec_t        vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every ready pulse must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (if_ready || mem_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 32'(1), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("ready_port", 32'(mem_ready), 32'(e.is_mem));
                    check("ready_both", 32'(if_ready & mem_ready), 32'(0));
                    check("rdata", e.is_mem ? mem_rdata : if_rdata, e.rdata);
                    check("bus_err", 32'(bus_err), 32'(e.err));
                end
            end else if (bus_err) begin
                check("err_without_ready", 32'(1), 32'(0));
            end
        end
    end

    // Counts bus transactions as rising edges of bus_req.
    always @(posedge clk) begin
        #1;
        if (bus_req && !bus_req_prev) bus_txn++;
        bus_req_prev = bus_req;
    end

    task automatic run_vec(input vec_t v);
        logic [31:0] other_prev;
        int unsigned lat;
        exp_t        e;
        other_prev = v.is_mem ? if_rdata : mem_rdata;
        e.is_mem = v.is_mem;
        e.rdata  = v.exp_rdata;
        e.err    = v.exp_err;
        sb_q.push_back(e);
        exp_txn++;
        if (v.is_mem) begin
            mem_req   = 1'b1;
            mem_we    = v.we;
            mem_addr  = v.addr;
            mem_wdata = v.wdata;
            mem_sel   = v.sel;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        tick();
        check("grant_latency", 32'(bus_req), 32'(1));
        check("bus_addr", bus_addr, v.addr);
        check("bus_we", 32'(bus_we), 32'(v.is_mem ? v.we : 1'b0));
        check("bus_sel", 32'(bus_sel), 32'(v.is_mem ? v.sel : 4'b1111));
        if (v.is_mem) check("bus_wdata", bus_wdata, v.wdata);
        check("stall_wait", 32'(stall), 32'(v.is_mem ? 6'b001111 : 6'b000011));
        if (v.exp_err) begin
            lat = 0;
            while (bus_req && lat < 10) begin
                tick();
                lat++;
            end
            check("timeout_cycles", lat, 32'(4));
        end else begin
            for (int unsigned i = 0; i < v.delay; i++) begin
                tick();
                check("hold_req", 32'(bus_req), 32'(1));
                check("hold_addr", bus_addr, v.addr);
            end
            bus_ack   = 1'b1;
            bus_rdata = v.bus_rdata;
            tick();
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            check("req_drop", 32'(bus_req), 32'(0));
        end
        check("ready_seen", 32'(v.is_mem ? mem_ready : if_ready), 32'(1));
        check("stall_resp", 32'(stall), 32'(0));
        check("other_rdata_held", v.is_mem ? if_rdata : mem_rdata, other_prev);
        if_req  = 1'b0;
        mem_req = 1'b0;
        tick();
        check("ready_once", 32'(if_ready | mem_ready), 32'(0));
        check("idle_no_req", 32'(bus_req), 32'(0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_sel = '0; bus_rdata = '0; bus_ack = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 2,   32'h2402_0005, 32'h2402_0005, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 0,   32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0800, 32'hDEAD_BEEF, 4'b0011, 3, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1,   32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0C00, 32'h0, 4'hF, 255, 32'h0, 32'h0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 255, 32'h0, 32'h0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'b1100, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0,   32'h8765_4321, 32'h8765_4321, 1'b0};

        // Reset values
        #1;
        check("rst_bus_req", 32'(bus_req), 32'(0));
        check("rst_bus_sel", 32'(bus_sel), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_rdata", if_rdata | mem_rdata, 32'h0);
        check("rst_ready", 32'(if_ready | mem_ready | bus_err), 32'(0));
        check("rst_stall", 32'(stall), 32'(0));
        // bus_ack while idle is ignored
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        tick();
        bus_ack = 1'b0;
        check("idle_ack_ignored", 32'(bus_req | if_ready | mem_ready), 32'(0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Simultaneous requests: MEM first, IF after RESP and an IDLE cycle
        if_req = 1'b1; if_addr = 32'h0000_0300;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0400; mem_sel = 4'hF;
        e.is_mem = 1'b1; e.rdata = 32'h1111_2222; e.err = 1'b0; sb_q.push_back(e);
        e.is_mem = 1'b0; e.rdata = 32'h3333_4444; e.err = 1'b0; sb_q.push_back(e);
        exp_txn += 2;
        tick();
        check("sim_grant_mem", bus_addr, 32'h0000_0400);
        check("sim_stall", 32'(stall), 32'(6'b001111));
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        tick();
        bus_ack = 1'b0;
        check("sim_mem_ready", 32'(mem_ready), 32'(1));
        check("sim_stall_if", 32'(stall), 32'(6'b000011));
        mem_req = 1'b0;
        tick();
        check("sim_idle_gap", 32'(bus_req), 32'(0));
        tick();
        check("sim_if_req", 32'(bus_req), 32'(1));
        check("sim_if_addr", bus_addr, 32'h0000_0300);
        check("sim_if_sel", 32'(bus_sel), 32'(4'b1111));
        bus_ack = 1'b1; bus_rdata = 32'h3333_4444;
        tick();
        bus_ack = 1'b0;
        if_req = 1'b0;
        tick();

        // Reset in the middle of a MEM access
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0500;
        mem_wdata = 32'hCAFE_F00D; mem_sel = 4'b1000;
        exp_txn++;
        tick();
        check("mid_req_up", 32'(bus_req), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_bus_req", 32'(bus_req), 32'(0));
        check("mid_bus_addr", bus_addr, 32'h0);
        check("mid_bus_wdata", bus_wdata, 32'h0);
        check("mid_bus_ctl", 32'({bus_we, bus_sel}), 32'(0));
        check("mid_rdata", if_rdata | mem_rdata, 32'h0);
        check("mid_ready", 32'(if_ready | mem_ready | bus_err), 32'(0));
        mem_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        tick();
        bus_ack = 1'b0;
        check("post_rst_ack", 32'(bus_req | mem_ready | if_ready), 32'(0));
        tick();
        check("post_rst_idle", 32'(bus_req | mem_ready | if_ready), 32'(0));
        check("post_rst_rdata", mem_rdata, 32'h0);

        tick();
        check("one_txn_per_req", bus_txn, exp_txn);
        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
